add_arbiter: RTL and testbench
==============================

# add_arbiter

Round-robin scheduler that time-shares one DATAWIDTH-bit adder among NREQ requesters. Each requester presents operand pairs with a level request; the block grants one requester per cycle, registers the chosen operands' sum into a single-entry result register, and tags it with the requester index. It sits between the HLSM datapath's functional-unit consumers and the one `add` resource they share, with downstream backpressure.

## Interface
- DATAWIDTH, 8, operand and sum width in bits
- NREQ, 4, number of requesters (2..16); IDW = $clog2(NREQ)
- Clk  input  1  rising-edge clock
- Rst  input  1  asynchronous, active-high reset
- req  input  NREQ  level request per requester; held until granted
- a_in  input  NREQ*DATAWIDTH  operand A, requester i at bits [i*DATAWIDTH +: DATAWIDTH]
- b_in  input  NREQ*DATAWIDTH  operand B, same packing
- gnt  output  NREQ  one-hot grant, combinational; at most one bit high
- sum_out  output  DATAWIDTH  registered sum
- sum_id  output  IDW  index of the requester that owns sum_out
- sum_valid  output  1  result register occupied
- out_ready  input  1  consumer accepts result when sum_valid && out_ready
- sum_cout  output  1  carry-out of the registered sum (only with ADD_ARB_CARRY_EN)

## Operation
- Result register states: EMPTY (sum_valid=0), FULL (sum_valid=1).
- can_issue = !sum_valid || out_ready (drain and refill in the same cycle allowed).
- Grant: if can_issue and req != 0, gnt selects first set req bit searching from (last+1) mod NREQ upward with wrap; otherwise gnt = 0.
- On a Clk edge with gnt[i]=1: sum_out <= a_in[i] + b_in[i] truncated to DATAWIDTH (modulo 2^DATAWIDTH), sum_id <= i, sum_valid <= 1, last <= i.
- On a Clk edge with sum_valid && out_ready and no grant: sum_valid <= 0; sum_out/sum_id hold their last values.
- FULL with out_ready=0: gnt = 0, result register, sum_id and last hold.
- last updates only on a grant; a requester dropping req before grant is simply skipped.
- Requester sees gnt[i] for exactly one cycle per accepted operation; it must keep req[i] and operands stable until the edge where gnt[i] is sampled high, and may deassert or present new operands in the following cycle.
- Unsigned arithmetic; no overflow flag beyond optional carry.

## Timing
- Reset (Rst high, asynchronous): sum_valid=0, sum_out=0, sum_id=0, last=NREQ-1 (so first search starts at requester 0), sum_cout=0; gnt=0 while Rst high.
- Latency: grant cycle N -> sum_valid/sum_out/sum_id visible in cycle N+1.
- Throughput: one result per cycle while out_ready=1.
- Fairness: with all req held high and out_ready=1, grants rotate 0,1,...,NREQ-1,0,...; any continuously requesting port is granted within NREQ issue opportunities.
- Rst asserted mid-operation: pending result discarded, pointer returns to reset value; requesters re-arbitrate from requester 0 after release.
- Simultaneous drain and grant: new result replaces the drained one in the same edge; sum_valid stays 1.

## Configuration
- ADD_ARB_CARRY_EN defined: adds output port sum_cout; on grant, sum_cout <= bit DATAWIDTH of the (DATAWIDTH+1)-bit sum a_in[i] + b_in[i]; holds with sum_out; reset 0.
- ADD_ARB_CARRY_EN undefined: sum_cout port absent; adder is DATAWIDTH bits, carry discarded.

## Test plan
- Reset: drive Rst high mid-stream with req=4'b1111 -> gnt=0, sum_valid=0, sum_out=0, sum_id=0; after release first grant is gnt=4'b0001.
- Single request: req=4'b0100, a=8'd100, b=8'd27, out_ready=1 -> gnt=4'b0100 one cycle, next cycle sum_out=127, sum_id=2, sum_valid=1.
- Round robin: req=4'b1111 held, out_ready=1 for 8 cycles -> sum_id sequence 0,1,2,3,0,1,2,3, one result per cycle.
- Backpressure: out_ready=0 while FULL with req=4'b0011 -> gnt=0, sum_out/sum_id stable; raise out_ready -> same-cycle drain and grant of next requester in rotation, sum_valid stays 1.
- Wrap-around arithmetic: a=8'd200, b=8'd100 -> sum_out=8'd44; with ADD_ARB_CARRY_EN sum_cout=1, with a=8'd1, b=8'd2 sum_cout=0.
- Skip dropped request: last=0, req=4'b1010 then req[1] dropped before grant -> grant goes to requester 3, sum_id=3.

Source files
------------

// File: rtl/add_arbiter.sv
// Round-robin arbiter that time-shares one DATAWIDTH-bit adder among NREQ requesters.
// Latency: a grant in cycle N makes sum_out/sum_id/sum_valid visible in cycle N+1; one result per cycle.
// Backpressure: while the result register is full and out_ready is low, no grant is issued and all state holds.
//
// Ports:
//   Clk        rising-edge clock
//   Rst        asynchronous active-high reset
//   req        level request per requester, held until granted
//   a_in/b_in  packed operands, requester i at [i*DATAWIDTH +: DATAWIDTH]
//   gnt        combinational one-hot grant (zero while Rst is high)
//   sum_out    registered sum, modulo 2^DATAWIDTH
//   sum_id     index of the requester owning sum_out
//   sum_valid  result register occupied
//   out_ready  consumer accepts the result when sum_valid && out_ready
//   sum_cout   carry-out of the registered sum (present only with ADD_ARB_CARRY_EN)
//
// Build option: define ADD_ARB_CARRY_EN to widen the adder by one bit and expose sum_cout.

module add_arbiter #(
    parameter int DATAWIDTH = 8,
    parameter int NREQ      = 4,
    localparam int IDW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*DATAWIDTH-1:0] a_in,
    input  logic [NREQ*DATAWIDTH-1:0] b_in,
    output logic [NREQ-1:0]           gnt,
    output logic [DATAWIDTH-1:0]      sum_out,
    output logic [IDW-1:0]            sum_id,
    output logic                      sum_valid,
`ifdef ADD_ARB_CARRY_EN
    output logic                      sum_cout,
`endif
    input  logic                      out_ready
);

    // ------------------------------------------------------------------
    // Result register occupancy
    // ------------------------------------------------------------------
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Registered result and round-robin pointer
    logic [DATAWIDTH-1:0] r_sum;
    logic [IDW-1:0]       r_id;
    logic [IDW-1:0]       r_last;

    // Arbitration wires
    logic                 w_can_issue;
    logic [NREQ-1:0]      w_gnt;
    logic [IDW-1:0]       w_gnt_id;
    logic                 w_grant;
    logic                 w_found;
    logic [IDW:0]         w_idx_ext;
    logic [IDW-1:0]       w_idx;

    // Datapath wires
    logic [DATAWIDTH-1:0] w_a;
    logic [DATAWIDTH-1:0] w_b;
    logic [DATAWIDTH-1:0] w_sum;

`ifdef ADD_ARB_CARRY_EN
    logic                 r_cout;
    logic [DATAWIDTH:0]   w_sum_ext;
    logic                 w_cout;
`endif

    // A new operation may enter when the register is empty or is being
    // drained on this same edge.
    assign w_can_issue = (r_state == ST_EMPTY) || out_ready;

    // ------------------------------------------------------------------
    // Round-robin search: start one past the last winner and wrap.
    // The index is computed one bit wider so (last + k) can be reduced
    // modulo NREQ for non-power-of-two requester counts.
    // ------------------------------------------------------------------
    always_comb begin
        w_gnt     = '0;
        w_gnt_id  = '0;
        w_found   = 1'b0;
        w_idx_ext = '0;
        w_idx     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx_ext = {1'b0, r_last} + (IDW+1)'(k);
            if (w_idx_ext >= (IDW+1)'(NREQ)) begin
                w_idx_ext = w_idx_ext - (IDW+1)'(NREQ);
            end
            w_idx = w_idx_ext[IDW-1:0];
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_gnt_id = w_idx;
            end
        end
        // Grant is suppressed during reset and while blocked downstream.
        if (w_found && w_can_issue && !Rst) begin
            w_gnt[w_gnt_id] = 1'b1;
        end
    end

    assign w_grant = |w_gnt;
    assign gnt     = w_gnt;

    // ------------------------------------------------------------------
    // Operand select for the granted requester
    // ------------------------------------------------------------------
    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt_id == IDW'(i)) begin
                w_a = a_in[i*DATAWIDTH +: DATAWIDTH];
                w_b = b_in[i*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

    // ------------------------------------------------------------------
    // Shared adder
    // ------------------------------------------------------------------
`ifdef ADD_ARB_CARRY_EN
    assign w_sum_ext = {1'b0, w_a} + {1'b0, w_b};
    assign w_sum     = w_sum_ext[DATAWIDTH-1:0];
    assign w_cout    = w_sum_ext[DATAWIDTH];
`else
    // Carry is discarded: result wraps modulo 2^DATAWIDTH.
    assign w_sum     = w_a + w_b;
`endif

    // ------------------------------------------------------------------
    // Occupancy FSM
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_grant) begin
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                // A grant while full implies out_ready: drain and refill together.
                if (w_grant) begin
                    w_state_nxt = ST_FULL;
                end else if (out_ready) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // ------------------------------------------------------------------
    // Result register and pointer. Pointer reset to NREQ-1 so the first
    // search after reset begins at requester 0. On drain without grant the
    // payload holds; only occupancy clears.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_sum  <= '0;
            r_id   <= '0;
            r_last <= IDW'(NREQ-1);
        end else if (w_grant) begin
            r_sum  <= w_sum;
            r_id   <= w_gnt_id;
            r_last <= w_gnt_id;
        end
    end

`ifdef ADD_ARB_CARRY_EN
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_cout <= 1'b0;
        end else if (w_grant) begin
            r_cout <= w_cout;
        end
    end

    assign sum_cout = r_cout;
`endif

    assign sum_out   = r_sum;
    assign sum_id    = r_id;
    assign sum_valid = (r_state == ST_FULL);

endmodule

// File: tb/tb_add_arbiter.sv
// Scoreboarded bench for add_arbiter: directed cases followed by random traffic.
// Expected results are pushed at grant time and popped by a separate monitor on each handshake.
// Inputs are driven at the falling edge; outputs are sampled a few ns later, away from the rising edge.

module tb_add_arbiter;

    localparam int DW   = 8;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 Clk = 1'b0;
    logic                 Rst = 1'b1;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ*DW-1:0]   a_in = '0;
    logic [NREQ*DW-1:0]   b_in = '0;
    logic [NREQ-1:0]      gnt;
    logic [DW-1:0]        sum_out;
    logic [IDW-1:0]       sum_id;
    logic                 sum_valid;
    logic                 out_ready = 1'b0;
`ifdef ADD_ARB_CARRY_EN
    logic                 sum_cout;
`endif

    add_arbiter #(.DATAWIDTH(DW), .NREQ(NREQ)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .sum_out   (sum_out),
        .sum_id    (sum_id),
        .sum_valid (sum_valid),
`ifdef ADD_ARB_CARRY_EN
        .sum_cout  (sum_cout),
`endif
        .out_ready (out_ready)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DW-1:0] s;
        int            id;
        logic          c;
    } exp_t;

    exp_t sb[$];

    // Reference model state: who won last, and whether a result is held.
    int m_last = NREQ - 1;
    bit m_full = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req_v);
        end
    endtask

    // Spec rule: nothing while reset or blocked; otherwise first requester
    // after the last winner, wrapping around.
    function automatic int model_pick();
        if (Rst) return -1;
        if (m_full && !out_ready) return -1;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (m_last + k) % NREQ;
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    // One clock cycle: drive inputs at the falling edge, check grant and
    // occupancy, then advance the model across the coming rising edge.
    task automatic step(input logic [NREQ-1:0] r, input logic ordy,
                        input logic [NREQ*DW-1:0] av, input logic [NREQ*DW-1:0] bv);
        int          w;
        logic [NREQ-1:0] eg;
        int          full_sum;
        exp_t        e;
        @(negedge Clk);
        req       = r;
        out_ready = ordy;
        a_in      = av;
        b_in      = bv;
        #2;
        w  = model_pick();
        eg = '0;
        if (w >= 0) eg[w] = 1'b1;
        chk("gnt", 32'(gnt), 32'(eg));
        chk("sum_valid", 32'(sum_valid), 32'(m_full));
        if (w >= 0) begin
            full_sum = int'(av[w*DW +: DW]) + int'(bv[w*DW +: DW]);
            e.s  = DW'(full_sum % 256);
            e.id = w;
            e.c  = (full_sum >= 256);
            sb.push_back(e);
            m_last = w;
            m_full = 1'b1;
        end else if (m_full && ordy) begin
            m_full = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Rst       = 1'b1;
        req       = 4'b1111;
        out_ready = 1'b1;
        #2;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_valid", 32'(sum_valid), 32'd0);
        chk("rst_sum", 32'(sum_out), 32'd0);
        chk("rst_id", 32'(sum_id), 32'd0);
`ifdef ADD_ARB_CARRY_EN
        chk("rst_cout", 32'(sum_cout), 32'd0);
`endif
        sb.delete();
        m_last = NREQ - 1;
        m_full = 1'b0;
        @(negedge Clk);
        Rst = 1'b0;
        req = '0;
    endtask

    // Monitor: every accepted result must match the oldest expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            #3;
            if (!Rst && sum_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result actual_id=%0d required=none", sum_id);
                end else begin
                    e = sb.pop_front();
                    chk("sb_sum", 32'(sum_out), 32'(e.s));
                    chk("sb_id", 32'(sum_id), 32'(e.id));
`ifdef ADD_ARB_CARRY_EN
                    chk("sb_cout", 32'(sum_cout), 32'(e.c));
`endif
                end
            end
        end
    end

    function automatic logic [NREQ*DW-1:0] ops(input int idx, input int v);
        logic [NREQ*DW-1:0] t;
        t = '0;
        t[idx*DW +: DW] = DW'(v);
        return t;
    endfunction

    initial begin
        logic [NREQ*DW-1:0] av, bv;
        logic [DW-1:0]      hold_sum;
        logic [IDW-1:0]     hold_id;

        do_reset();

        // Round robin with everyone requesting: ids 0,1,2,3,0,1,2,3.
        for (int i = 0; i < NREQ; i++) begin
            av[i*DW +: DW] = DW'(10 * i + 1);
            bv[i*DW +: DW] = DW'(i + 5);
        end
        for (int k = 0; k < 8; k++) begin
            step(4'b1111, 1'b1, av, bv);
            if (k == 0) chk("rr_first_gnt", 32'(gnt), 32'd1);
            else        chk("rr_id", 32'(sum_id), 32'((k - 1) % NREQ));
        end
        step(4'b0000, 1'b1, av, bv);
        chk("rr_last_id", 32'(sum_id), 32'd3);

        // Single request from requester 2: 100 + 27.
        step(4'b0100, 1'b1, ops(2, 100), ops(2, 27));
        chk("single_gnt", 32'(gnt), 32'b0100);
        step(4'b0000, 1'b1, ops(2, 100), ops(2, 27));
        chk("single_sum", 32'(sum_out), 32'd127);
        chk("single_id", 32'(sum_id), 32'd2);

        // Backpressure: fill, hold with out_ready low, then drain+grant together.
        av = ops(0, 3) | ops(1, 4);
        bv = ops(0, 30) | ops(1, 40);
        step(4'b0011, 1'b0, av, bv);
        step(4'b0011, 1'b0, av, bv);
        hold_sum = sum_out;
        hold_id  = sum_id;
        chk("bp_held_id", 32'(hold_id), 32'd0);
        step(4'b0011, 1'b0, av, bv);
        chk("bp_gnt_blocked", 32'(gnt), 32'd0);
        chk("bp_sum_stable", 32'(sum_out), 32'(hold_sum));
        step(4'b0011, 1'b1, av, bv);
        chk("bp_release_gnt", 32'(gnt), 32'b0010);
        step(4'b0000, 1'b0, av, bv);
        chk("bp_valid_kept", 32'(sum_valid), 32'd1);
        chk("bp_next_id", 32'(sum_id), 32'd1);

        // Wrap-around arithmetic on requester 0.
        step(4'b0001, 1'b1, ops(0, 200), ops(0, 100));
        step(4'b0001, 1'b1, ops(0, 1), ops(0, 2));
        chk("wrap_sum", 32'(sum_out), 32'd44);
`ifdef ADD_ARB_CARRY_EN
        chk("wrap_cout", 32'(sum_cout), 32'd1);
`endif
        step(4'b0000, 1'b0, ops(0, 1), ops(0, 2));
        chk("small_sum", 32'(sum_out), 32'd3);
`ifdef ADD_ARB_CARRY_EN
        chk("small_cout", 32'(sum_cout), 32'd0);
`endif

        // Skip dropped request: last=0, req 1 withdraws while blocked.
        av = ops(1, 7) | ops(3, 9);
        bv = ops(1, 8) | ops(3, 11);
        step(4'b1010, 1'b0, av, bv);
        step(4'b1000, 1'b1, av, bv);
        chk("skip_gnt", 32'(gnt), 32'b1000);
        step(4'b0000, 1'b1, av, bv);
        chk("skip_id", 32'(sum_id), 32'd3);

        // Reset mid-stream while full and requested.
        step(4'b1111, 1'b0, av, bv);
        step(4'b1111, 1'b0, av, bv);
        do_reset();
        step(4'b1111, 1'b1, av, bv);
        chk("post_rst_gnt", 32'(gnt), 32'b0001);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                av[i*DW +: DW] = DW'($urandom);
                bv[i*DW +: DW] = DW'($urandom);
            end
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end
            step(NREQ'($urandom), ($urandom_range(0, 3) != 0), av, bv);
        end

        // Drain and confirm nothing is left outstanding.
        step(4'b0000, 1'b1, av, bv);
        step(4'b0000, 1'b1, av, bv);
        step(4'b0000, 1'b1, av, bv);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
